// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic pipeline stage register with a valid/ready handshake,
//            synchronous flush and a saturating back-pressure (stall) counter.
//            Any stage payload is packed into WIDTH bits.
// Revision : 1.0 - initial release
//
// Parameters
//   WIDTH        payload width in bits (>= 1)
//   STALL_CNT_W  stall counter width in bits (>= 1)
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   upstream presents a payload
//   in_ready   out  stage accepts a payload this cycle
//   in_data    in   upstream payload
//   flush      in   discard all held and incoming payloads
//   out_valid  out  out_data holds a valid payload
//   out_ready  in   downstream consumes this cycle
//   out_data   out  held payload, driven directly from a register
//   stall_cnt  out  saturating count of cycles with out_valid && !out_ready
//
// Build option
//   PIPE_STAGE_REG_SKID_EN  when defined, adds a skid entry (capacity 2) so
//                           that in_ready comes straight from a register.
//                           When undefined, capacity is 1 and in_ready
//                           depends combinationally on out_ready.
// ============================================================================
module pipe_stage_reg #(
    parameter int WIDTH       = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] c_STALL_ONE = STALL_CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] c_STALL_MAX = '1;

    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_stall;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign stall_cnt = r_stall_cnt;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_stall    = r_out_valid && !out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    // ------------------------------------------------------------------
    // Main entry plus skid entry. The skid only fills when the main entry
    // is occupied and the consumer stalls, so skid_valid implies
    // out_valid; in_ready is just "skid is free".
    // ------------------------------------------------------------------
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    assign in_ready = !r_skid_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (r_skid_valid && out_ready) begin
            // Main is being consumed; promote the older skid payload.
            // in_ready is low here, so no input transfer competes.
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_skid_valid <= 1'b0;
        end else if (w_in_xfer && (!r_out_valid || out_ready)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
        end else if (w_in_xfer) begin
            // Main is stalled; park the new payload behind it.
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end
`else
    // ------------------------------------------------------------------
    // Single entry. Accept when empty or when the held payload leaves in
    // the same cycle, which keeps full throughput at the cost of a
    // combinational out_ready -> in_ready path.
    // ------------------------------------------------------------------
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    // Stall counter: only reset clears it; flush cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!flush && w_stall && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. A queue-based model of
//            the stage (FIFO of the configured capacity) predicts in_ready,
//            out_valid, out_data and stall_cnt every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int W    = 64;
    localparam int SW   = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH       (W),
        .STALL_CNT_W (SW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ordered list of held payloads, the last value shown
    // on out_data, and the stall count.
    logic [W-1:0] q[$];
    logic [W-1:0] m_last;
    int           m_stall;

`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    function automatic logic exp_in_ready(input logic ordy);
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || ordy;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check in_ready, advance model at the
    // edge, then check the registered outputs half a cycle later.
    task automatic cycle(input logic rst_i, input logic iv, input logic [W-1:0] id,
                         input logic ordy, input logic fl);
        logic exp_rdy;
        logic pop;
        logic push;
        reset     = rst_i;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = exp_in_ready(ordy);
        check("in_ready", W'(in_ready), W'(exp_rdy));
        @(posedge clk);
        if (rst_i || fl) begin
            q.delete();
            m_last = '0;
            if (rst_i) m_stall = 0;
        end else begin
            pop  = (q.size() > 0) && ordy;
            push = iv && exp_rdy;
            if ((q.size() > 0) && !ordy && (m_stall < SMAX)) m_stall++;
            if (pop)  m_last = q.pop_front();
            if (push) q.push_back(id);
        end
        @(negedge clk);
        check("out_valid", W'(out_valid), W'(q.size() > 0));
        check("out_data",  out_data, (q.size() > 0) ? q[0] : m_last);
        check("stall_cnt", W'(stall_cnt), W'(m_stall));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        m_last    = '0;
        m_stall   = 0;
        @(negedge clk);

        // Reset held for two cycles
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_out_data",  out_data, '0);
        check("rst_stall",     W'(stall_cnt), '0);
        #1;
        check("rst_in_ready",  W'(in_ready), W'(1));

        // Streaming 1..4 with no bubbles
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, W'(i), 1'b1, 1'b0);
            check("stream_data", out_data, W'(i));
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Back-pressure: A, then B and C with out_ready low
        cycle(1'b0, 1'b1, 64'hA, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 64'hB, 1'b0, 1'b0);
        check("bp_main_A", out_data, 64'hA);
        cycle(1'b0, 1'b1, 64'hC, 1'b0, 1'b0);
        check("bp_hold_A", out_data, 64'hA);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 64'hC, 1'b1, 1'b0);
            if (q.size() == 0) break;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Flush with the stage full and 0x55 arriving
        cycle(1'b0, 1'b1, 64'h1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 64'h2, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 64'h55, 1'b0, 1'b1);
        check("flush_valid", W'(out_valid), '0);
        check("flush_data",  out_data, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("flush_no55", W'(out_data == 64'h55), '0);

        // Stall counter saturation, flush hold, reset clear
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 64'h77, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("stall_sat", W'(stall_cnt), W'(SMAX));
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("stall_flush_hold", W'(stall_cnt), W'(SMAX));
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("stall_reset", W'(stall_cnt), '0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) != 0,
                  {$urandom, $urandom},
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
